// File: rtl/display_mode_controller.sv
// Push-button mode sequencer for the 7-segment source mux: synchronizer, debounce, short/long press, mode FSM.
// Optional auto-return to clock view enabled by defining DISPLAY_MODE_TIMEOUT_EN.
module display_mode_controller #(
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int LONG_PRESS_CYCLES = 100000000,
  parameter int TIMEOUT_SECONDS   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  input  logic       tick_1hz,
  input  logic       sw_running,
  output logic [2:0] select,
  output logic       mode_changed
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LONG_PRESS_CYCLES + 1);

  typedef enum logic [1:0] {
    MODE_CLOCK = 2'd0,
    MODE_SEC   = 2'd1,
    MODE_SW    = 2'd2,
    MODE_OFF   = 2'd3
  } mode_e;

  mode_e          state, state_next;
  logic           key_meta, key_sync;
  logic           stable_n, stable_d;
  logic [DW-1:0]  deb_cnt;
  logic [LW-1:0]  hold_cnt;
  logic           long_flag;
  logic           pressed, key_edge, short_evt, long_evt, timeout_evt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
      stable_n <= 1'b1;
      stable_d <= 1'b1;
      deb_cnt  <= '0;
    end else begin
      key_meta <= key_n;
      key_sync <= key_meta;
      stable_d <= stable_n;
      if (key_sync == stable_n) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        // DEBOUNCE_CYCLES consecutive differing cycles accept the new level.
        stable_n <= key_sync;
        deb_cnt  <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign pressed  = ~stable_n;
  assign key_edge = stable_n != stable_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt  <= '0;
      long_flag <= 1'b0;
    end else if (!pressed) begin
      hold_cnt  <= '0;
      long_flag <= 1'b0;
    end else begin
      if (hold_cnt != LW'(LONG_PRESS_CYCLES)) hold_cnt <= hold_cnt + 1'b1;
      if (long_evt) long_flag <= 1'b1;
    end
  end

  // long_flag is still set in the release-edge cycle, which suppresses the short event after a long press.
  assign long_evt  = pressed && (hold_cnt == LW'(LONG_PRESS_CYCLES)) && !long_flag;
  assign short_evt = stable_n && !stable_d && !long_flag;

`ifdef DISPLAY_MODE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_SECONDS + 1);

  logic [TW-1:0] to_cnt;
  logic          to_active;

  assign to_active   = (state == MODE_SEC) || ((state == MODE_SW) && !sw_running);
  assign timeout_evt = to_active && tick_1hz && (to_cnt == TW'(TIMEOUT_SECONDS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if ((state_next != state) || key_edge || !to_active) begin
      to_cnt <= '0;
    end else if (tick_1hz) begin
      to_cnt <= timeout_evt ? '0 : to_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout_inputs;
  assign unused_timeout_inputs = ^{tick_1hz, sw_running, key_edge};
  assign timeout_evt           = 1'b0;
`endif

  // NOTE: state_next gets its default first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      MODE_CLOCK: begin
        if (short_evt)     state_next = MODE_SEC;
        else if (long_evt) state_next = MODE_OFF;
      end
      MODE_SEC: begin
        if (short_evt)        state_next = MODE_SW;
        else if (long_evt)    state_next = MODE_OFF;
        else if (timeout_evt) state_next = MODE_CLOCK;
      end
      MODE_SW: begin
        if (short_evt)        state_next = MODE_CLOCK;
        else if (long_evt)    state_next = MODE_OFF;
        else if (timeout_evt) state_next = MODE_CLOCK;
      end
      MODE_OFF: begin
        if (short_evt || long_evt) state_next = MODE_CLOCK;
      end
      default: state_next = MODE_CLOCK;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= MODE_CLOCK;
      mode_changed <= 1'b0;
    end else begin
      state        <= state_next;
      mode_changed <= state_next != state;
    end
  end

  assign select = {1'b0, state};

endmodule

// File: tb/tb_display_mode_controller.sv
// Directed bench for display_mode_controller with small debounce/long-press/timeout parameters.
// Expectations follow whether DISPLAY_MODE_TIMEOUT_EN is defined for the build.
module tb_display_mode_controller;

`ifdef DISPLAY_MODE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       key_n;
  logic       tick_1hz;
  logic       sw_running;
  logic [2:0] select;
  logic       mode_changed;

  int n_checks = 0;
  int n_err    = 0;
  int pulse_total = 0;

  display_mode_controller #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(20),
    .TIMEOUT_SECONDS  (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_n       (key_n),
    .tick_1hz    (tick_1hz),
    .sw_running  (sw_running),
    .select      (select),
    .mode_changed(mode_changed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mode_changed) pulse_total++;

  typedef struct {
    string name;
    bit    rst;
    int    low;
    int    high;
    int    reps;
    int    ticks;
    bit    swr;
    int    sel;
    int    chg;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    key_n      = 1'b1;
    tick_1hz   = 1'b0;
    sw_running = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int start;
    if (v.rst) do_reset();
    #1 start = pulse_total;
    sw_running = v.swr;
    for (int r = 0; r < v.reps; r++) begin
      key_n = 1'b0;
      repeat (v.low) @(negedge clk);
      key_n = 1'b1;
      repeat (v.high) @(negedge clk);
    end
    for (int t = 0; t < v.ticks; t++) begin
      tick_1hz = 1'b1;
      @(negedge clk);
      tick_1hz = 1'b0;
      repeat (3) @(negedge clk);
    end
    #1;
    check({v.name, " select"}, int'(select), v.sel);
    check({v.name, " pulses"}, pulse_total - start, v.chg);
  endtask

  initial begin
    int start;

    vecs[0]  = '{"reset",        1, 0,  0,  0, 0,  0, 0, 0};
    vecs[1]  = '{"short clk-sec", 0, 10, 10, 1, 0,  0, 1, 1};
    vecs[2]  = '{"short sec-sw",  0, 10, 10, 1, 0,  0, 2, 1};
    vecs[3]  = '{"short sw-clk",  0, 10, 10, 1, 0,  0, 0, 1};
    vecs[4]  = '{"glitches",      0, 3,  3,  5, 0,  0, 0, 0};
    vecs[5]  = '{"short to sec",  0, 10, 10, 1, 0,  0, 1, 1};
    vecs[6]  = '{"long sec-off",  0, 30, 10, 1, 0,  0, 3, 1};
    vecs[7]  = '{"long off-clk",  0, 30, 10, 1, 0,  0, 0, 1};
    vecs[8]  = '{"short to sec2", 0, 10, 10, 1, 0,  0, 1, 1};
    vecs[9]  = '{"sec timeout",   0, 0,  0,  0, 3,  0, TO_EN ? 0 : 1, TO_EN ? 1 : 0};
    vecs[10] = '{"rst to sec",    1, 10, 10, 1, 0,  0, 1, 1};
    vecs[11] = '{"sec to sw",     0, 10, 10, 1, 0,  0, 2, 1};
    vecs[12] = '{"sw running",    0, 0,  0,  0, 5,  1, 2, 0};
    vecs[13] = '{"sw timeout",    0, 0,  0,  0, 3,  0, TO_EN ? 0 : 2, TO_EN ? 1 : 0};
    vecs[14] = '{"sec 10 ticks",  1, 10, 10, 1, 10, 0, TO_EN ? 0 : 1, TO_EN ? 2 : 1};

    do_reset();
    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // Exact latency: release accepted at the 6th edge, select and mode_changed at the 7th.
    do_reset();
    key_n = 1'b0;
    repeat (10) @(negedge clk);
    key_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 6) begin
        check("lat pre mc", int'(mode_changed), 0);
        check("lat pre sel", int'(select), 0);
      end
      if (i == 7) begin
        check("lat mc", int'(mode_changed), 1);
        check("lat sel", int'(select), 1);
      end
      if (i == 8) check("lat mc one-shot", int'(mode_changed), 0);
    end

    // Asynchronous reset during a held press; key still low afterwards must re-debounce.
    key_n = 1'b0;
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async rst sel", int'(select), 0);
    check("async rst mc", int'(mode_changed), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    key_n = 1'b1;
    #1 start = pulse_total;
    repeat (20) @(negedge clk);
    #1;
    check("held-through-rst sel", int'(select), 0);
    check("held-through-rst pulses", pulse_total - start, 0);

    // Third tick lands on the short-press event cycle: the button wins.
    do_reset();
    key_n = 1'b0;
    repeat (10) @(negedge clk);
    key_n = 1'b1;
    repeat (10) @(negedge clk);
    key_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int t = 0; t < 2; t++) begin
      tick_1hz = 1'b1;
      @(negedge clk);
      tick_1hz = 1'b0;
      @(negedge clk);
    end
    check("coinc before sel", int'(select), 1);
    key_n = 1'b1;
    repeat (6) @(negedge clk);
    tick_1hz = 1'b1;
    @(negedge clk);
    tick_1hz = 1'b0;
    check("coinc sel", int'(select), 2);
    check("coinc mc", int'(mode_changed), 1);
    repeat (10) @(negedge clk);
    check("coinc settled sel", int'(select), 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
